// File: rtl/dec_hazard_ctrl.sv
// Decode-stage load-use/WAW interlock and front-end flush sequencer for the RVS192 pipeline.
// Optional performance counters are built when DEC_HAZARD_PERF_EN is defined.
module dec_hazard_ctrl #(
  parameter int NUM_REGS     = 32,
  parameter int MAX_PEND     = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 32,
  localparam int PW          = $clog2(MAX_PEND + 1),
  localparam int FCW         = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dec_valid,
  input  logic [4:0]           dec_rs1,
  input  logic [4:0]           dec_rs2,
  input  logic [4:0]           dec_rd,
  input  logic                 dec_use_rs1,
  input  logic                 dec_use_rs2,
  input  logic                 dec_reg_wen,
  input  logic                 dec_load,
  input  logic                 wb_load_valid,
  input  logic [4:0]           wb_load_rd,
  input  logic                 ex_redirect,
  output logic                 dec_issue,
  output logic                 stall_fe,
  output logic                 stall_dec,
  output logic                 bubble_ex,
  output logic                 flush_fe,
  output logic                 flush_dec,
  output logic [PW-1:0]        pend_cnt,
  output logic [NUM_REGS-1:0]  scoreboard,
  output logic [1:0]           dbg_state
`ifdef DEC_HAZARD_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0] perf_stall_cycles,
  output logic [CNT_WIDTH-1:0] perf_flush_cycles
`endif
);

  // dbg_state encoding: 0 = RUN, 1 = STALL, 2 = FLUSH
  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_CYCLES - 1);

  state_t               state;
  state_t               state_nxt;
  logic [FCW-1:0]       fcnt;
  logic [FCW-1:0]       fcnt_nxt;

  logic [NUM_REGS-1:0]  clr_mask;
  logic [NUM_REGS-1:0]  set_mask;
  logic [NUM_REGS-1:0]  sb_eff;
  logic                 clr_hit;
  logic                 do_set;
  logic                 raw_rs1;
  logic                 raw_rs2;
  logic                 waw_rd;
  logic                 pend_full;
  logic                 hazard;
  logic                 flush_any;
  logic                 stall_any;

  // A returning load is bypassed through the write-through regfile in the same cycle.
  always_comb begin
    clr_mask = '0;
    if (wb_load_valid && (wb_load_rd != 5'd0)) clr_mask[wb_load_rd] = 1'b1;
  end

  assign sb_eff  = scoreboard & ~clr_mask;
  assign clr_hit = |(scoreboard & clr_mask);

  assign raw_rs1   = dec_use_rs1 && (dec_rs1 != 5'd0) && sb_eff[dec_rs1];
  assign raw_rs2   = dec_use_rs2 && (dec_rs2 != 5'd0) && sb_eff[dec_rs2];
  assign waw_rd    = dec_reg_wen && (dec_rd != 5'd0) && sb_eff[dec_rd];
  // A full tracker only blocks a new load when no slot frees up this cycle.
  assign pend_full = dec_load && (dec_rd != 5'd0) && (pend_cnt == PW'(MAX_PEND)) && !clr_hit;
  assign hazard    = dec_valid && (raw_rs1 || raw_rs2 || waw_rd || pend_full);

  // Redirect wins over stall; outputs are held low while reset is asserted.
  assign flush_any = rst_n && (ex_redirect || (state == S_FLUSH));
  assign stall_any = rst_n && hazard && !flush_any;

  assign flush_fe  = flush_any;
  assign flush_dec = flush_any;
  assign stall_fe  = stall_any;
  assign stall_dec = stall_any;
  assign bubble_ex = stall_any;
  assign dec_issue = rst_n && dec_valid && !hazard && !flush_any;
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    case (state)
      S_RUN: begin
        if (ex_redirect) begin
          state_nxt = S_FLUSH;
          fcnt_nxt  = FLUSH_LOAD;
        end else if (hazard) begin
          state_nxt = S_STALL;
        end
      end
      S_STALL: begin
        if (ex_redirect) begin
          state_nxt = S_FLUSH;
          fcnt_nxt  = FLUSH_LOAD;
        end else if (!hazard) begin
          state_nxt = S_RUN;
        end
      end
      S_FLUSH: begin
        if (ex_redirect) begin
          fcnt_nxt = FLUSH_LOAD;
        end else if (fcnt == '0) begin
          state_nxt = S_RUN;
        end else begin
          fcnt_nxt = fcnt - 1'b1;
        end
      end
      default: begin
        state_nxt = S_RUN;
        fcnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RUN;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  always_comb begin
    set_mask = '0;
    do_set   = dec_issue && dec_load && (dec_rd != 5'd0);
    if (do_set) set_mask[dec_rd] = 1'b1;
  end

  // pend_cnt tracks the population of the scoreboard; set+clear in one cycle cancels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scoreboard <= '0;
      pend_cnt   <= '0;
    end else begin
      scoreboard <= sb_eff | set_mask;
      if (do_set && !clr_hit) begin
        pend_cnt <= pend_cnt + 1'b1;
      end else if (!do_set && clr_hit) begin
        pend_cnt <= pend_cnt - 1'b1;
      end
    end
  end

`ifdef DEC_HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cycles <= '0;
      perf_flush_cycles <= '0;
    end else begin
      if (stall_any && !(&perf_stall_cycles)) perf_stall_cycles <= perf_stall_cycles + 1'b1;
      if (flush_any && !(&perf_flush_cycles)) perf_flush_cycles <= perf_flush_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dec_hazard_ctrl.sv
// Bench for dec_hazard_ctrl: directed scenarios then randomized traffic against a
// register-set / flush-countdown reference model.
module tb_dec_hazard_ctrl;
  localparam int NUM_REGS     = 32;
  localparam int MAX_PEND     = 4;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_WIDTH    = 32;
  localparam int PW           = $clog2(MAX_PEND + 1);
  localparam int ST_RUN = 0, ST_STALL = 1, ST_FLUSH = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                dec_valid = 1'b0;
  logic [4:0]          dec_rs1 = '0, dec_rs2 = '0, dec_rd = '0;
  logic                dec_use_rs1 = 1'b0, dec_use_rs2 = 1'b0;
  logic                dec_reg_wen = 1'b0, dec_load = 1'b0;
  logic                wb_load_valid = 1'b0;
  logic [4:0]          wb_load_rd = '0;
  logic                ex_redirect = 1'b0;
  logic                dec_issue, stall_fe, stall_dec, bubble_ex, flush_fe, flush_dec;
  logic [PW-1:0]       pend_cnt;
  logic [NUM_REGS-1:0] scoreboard;
  logic [1:0]          dbg_state;
`ifdef DEC_HAZARD_PERF_EN
  logic [CNT_WIDTH-1:0] perf_stall_cycles, perf_flush_cycles;
`endif

  dec_hazard_ctrl #(
    .NUM_REGS(NUM_REGS), .MAX_PEND(MAX_PEND),
    .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
    .dec_reg_wen(dec_reg_wen), .dec_load(dec_load),
    .wb_load_valid(wb_load_valid), .wb_load_rd(wb_load_rd),
    .ex_redirect(ex_redirect),
    .dec_issue(dec_issue), .stall_fe(stall_fe), .stall_dec(stall_dec),
    .bubble_ex(bubble_ex), .flush_fe(flush_fe), .flush_dec(flush_dec),
    .pend_cnt(pend_cnt), .scoreboard(scoreboard), .dbg_state(dbg_state)
`ifdef DEC_HAZARD_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_flush_cycles(perf_flush_cycles)
`endif
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: set of pending load destinations plus remaining flush cycles
  bit  m_pend[NUM_REGS];
  int  m_rem;
  int  m_state;
  bit  m_haz, m_flush, m_stall, m_issue;
  longint m_pstall, m_pflush;

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) m_pend[i] = 1'b0;
    m_rem = 0; m_state = ST_RUN; m_pstall = 0; m_pflush = 0;
    m_haz = 0; m_flush = 0; m_stall = 0; m_issue = 0;
  endtask

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < NUM_REGS; i++) n += int'(m_pend[i]);
    return n;
  endfunction

  function automatic logic [NUM_REGS-1:0] m_vec();
    logic [NUM_REGS-1:0] v = '0;
    for (int i = 0; i < NUM_REGS; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic bit clr_hits(input logic [4:0] r);
    return wb_load_valid && (wb_load_rd == r) && (r != 0);
  endfunction

  function automatic bit busy(input logic [4:0] r);
    return (r != 0) && m_pend[r] && !clr_hits(r);
  endfunction

  task automatic eval_and_check();
    bit any_clr;
    any_clr = (wb_load_rd != 0) && wb_load_valid && m_pend[wb_load_rd];
    m_haz = dec_valid && ((dec_use_rs1 && busy(dec_rs1)) || (dec_use_rs2 && busy(dec_rs2)) ||
            (dec_reg_wen && busy(dec_rd)) ||
            (dec_load && dec_rd != 0 && m_count() == MAX_PEND && !any_clr));
    m_flush = ex_redirect || (m_rem > 0);
    m_stall = m_haz && !m_flush;
    m_issue = dec_valid && !m_haz && !m_flush;
    check("issue", dec_issue, m_issue);
    check("stall_fe", stall_fe, m_stall);
    check("stall_dec", stall_dec, m_stall);
    check("bubble_ex", bubble_ex, m_stall);
    check("flush_fe", flush_fe, m_flush);
    check("flush_dec", flush_dec, m_flush);
    check("pend_cnt", pend_cnt, m_count());
    check("scoreboard", scoreboard, m_vec());
    check("state", dbg_state, m_state);
`ifdef DEC_HAZARD_PERF_EN
    check("perf_stall", perf_stall_cycles, m_pstall);
    check("perf_flush", perf_flush_cycles, m_pflush);
`endif
  endtask

  // driver: called just after a falling edge
  task automatic drive(input bit dv, input bit [4:0] rs1, input bit [4:0] rs2, input bit [4:0] rd,
                       input bit u1, input bit u2, input bit wen, input bit ld,
                       input bit wbv, input bit [4:0] wbrd, input bit redir);
    dec_valid = dv; dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd;
    dec_use_rs1 = u1; dec_use_rs2 = u2; dec_reg_wen = wen; dec_load = ld;
    wb_load_valid = wbv; wb_load_rd = wbrd; ex_redirect = redir;
    #1;
    eval_and_check();
  endtask

  task automatic tick();
    @(posedge clk);
    if (wb_load_valid && wb_load_rd != 0) m_pend[wb_load_rd] = 1'b0;
    if (m_issue && dec_load && dec_rd != 0) m_pend[dec_rd] = 1'b1;
    if (m_stall) m_pstall++;
    if (m_flush) m_pflush++;
    if (ex_redirect) m_rem = FLUSH_CYCLES;
    else if (m_rem > 0) m_rem--;
    if (m_rem > 0) m_state = ST_FLUSH;
    else if (m_state == ST_FLUSH) m_state = ST_RUN;
    else m_state = m_haz ? ST_STALL : ST_RUN;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
  endtask
  task automatic lw(input bit [4:0] rd, input bit wbv, input bit [4:0] wbrd);
    drive(1, 0, 0, rd, 0, 0, 1, 1, wbv, wbrd, 0);
  endtask
  task automatic add(input bit [4:0] rs1, input bit [4:0] rs2, input bit wbv, input bit [4:0] wbrd,
                     input bit redir);
    drive(1, rs1, rs2, 5'd9, 1, 1, 1, 0, wbv, wbrd, redir);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_issue"}, dec_issue, 0);
    check({tag, "_stall"}, {stall_fe, stall_dec, bubble_ex}, 0);
    check({tag, "_flush"}, {flush_fe, flush_dec}, 0);
    check({tag, "_pend"}, pend_cnt, 0);
    check({tag, "_sb"}, scoreboard, 0);
    check({tag, "_state"}, dbg_state, ST_RUN);
  endtask

  initial begin
    // reset
    model_reset();
    rst_n = 1'b0;
    #22;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // load-use RAW with same-cycle writeback release
    lw(5, 0, 0); tick();
    add(5, 0, 0, 0, 0);
    check("lu_stall", {stall_dec, bubble_ex}, 2'b11);
    check("lu_sb5", scoreboard[5], 1);
    check("lu_pend", pend_cnt, 1);
    tick();
    add(5, 0, 1, 5, 0);
    check("lu_bypass_issue", dec_issue, 1);
    check("lu_bypass_stall", stall_dec, 0);
    tick();
    idle();
    check("lu_sb_clear", scoreboard, 0);

    // x0 never tracked
    lw(0, 0, 0); tick();
    add(0, 0, 0, 0, 0);
    check("x0_sb", scoreboard, 0);
    check("x0_issue", dec_issue, 1);
    tick();

    // pending limit with same-cycle free slot
    for (int r = 1; r <= 4; r++) begin lw(5'(r), 0, 0); tick(); end
    lw(6, 0, 0);
    check("lim_stall", stall_dec, 1);
    check("lim_pend", pend_cnt, 4);
    tick();
    lw(6, 1, 2);
    check("lim_issue", dec_issue, 1);
    tick();
    idle();
    check("lim_pend_after", pend_cnt, 4);
    check("lim_sb2", scoreboard[2], 0);
    check("lim_sb6", scoreboard[6], 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd1, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd3, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd4, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd6, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd6, 0); tick();  // writeback to non-pending reg
    check("wb_nonpending_pend", pend_cnt, 0);

    // redirect during stall
    lw(7, 0, 0); tick();
    add(7, 0, 0, 0, 0); tick();
    add(7, 0, 0, 0, 1);
    check("rd_flush", {flush_fe, flush_dec}, 2'b11);
    check("rd_nostall", stall_dec, 0);
    check("rd_noissue", dec_issue, 0);
    tick();
    add(7, 0, 0, 0, 0); tick();
    add(7, 0, 0, 0, 0);
    check("rd_flush_2nd", flush_dec, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 0);
    check("rd_flush_done", flush_dec, 0);
    check("rd_state_run", dbg_state, ST_RUN);
    check("rd_sb7_kept", scoreboard[7], 1);
    tick();

    // back-to-back redirect
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    idle(); idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("b2b_done", flush_dec, 0);
    tick();

    // async reset while loads pending and flushing
    for (int r = 1; r <= 3; r++) begin lw(5'(r), 0, 0); tick(); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    add(1, 2, 0, 0, 1);
    check("ar_pre_pend", pend_cnt, 3);
    check("ar_pre_state", dbg_state, ST_FLUSH);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    add(1, 2, 0, 0, 0);
    check("ar_issue", dec_issue, 1);
    tick();
    add(3, 4, 0, 0, 0);
    check("ar_issue2", dec_issue, 1);
    tick();

    // randomized traffic, biased towards a few registers to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      bit [4:0] rs1, rs2, rd, wbrd;
      bit dv, u1, u2, wen, ld, wbv, redir;
      rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
      rd = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      dv = $urandom_range(0, 9) < 8; u1 = $urandom_range(0, 1); u2 = $urandom_range(0, 1);
      ld = $urandom_range(0, 9) < 4; wen = ld | ($urandom_range(0, 1) == 1);
      wbv = $urandom_range(0, 9) < 3; wbrd = 5'($urandom_range(0, 7));
      redir = $urandom_range(0, 19) == 0;
      drive(dv, rs1, rs2, rd, u1, u2, wen, ld, wbv, wbrd, redir);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dec_hazard_ctrl.md
Name: dec_hazard_ctrl

Overview:
- Decode-stage interlock and flush sequencer for the RVS192 5-stage pipeline.
- Sits beside the instruction decoder and consumes its register indices and control bits (reg_wen, cpu_read).
- Keeps a load scoreboard of destination registers whose data has not yet returned, and stalls decode on RAW/WAW hazards against those registers.
- Sequences multi-cycle front-end flushes on an EX-stage redirect.

Parameters:
- NUM_REGS, 32: architectural register count; scoreboard width.
- MAX_PEND, 4: maximum outstanding tracked loads.
- FLUSH_CYCLES, 2: cycles flush_fe/flush_dec stay asserted per redirect (≥1).
- CNT_WIDTH, 32: performance counter width (optional feature only).

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  reset, asynchronous, active-low.
- dec_valid  in  1  decode holds a valid instruction.
- dec_rs1  in  5  source register 1 index from decoder.
- dec_rs2  in  5  source register 2 index from decoder.
- dec_rd  in  5  destination register index from decoder.
- dec_use_rs1  in  1  instruction reads rs1.
- dec_use_rs2  in  1  instruction reads rs2.
- dec_reg_wen  in  1  instruction writes rd.
- dec_load  in  1  instruction is a load (cpu_read).
- wb_load_valid  in  1  load data written to regfile this cycle.
- wb_load_rd  in  5  destination of returning load.
- ex_redirect  in  1  taken branch/jump resolved in EX; younger instructions are wrong-path.
- dec_issue  out  1  decode instruction advances to EX this cycle.
- stall_fe  out  1  hold PC/fetch register.
- stall_dec  out  1  hold IF/DEC register.
- bubble_ex  out  1  load NOP into DEC/EX register.
- flush_fe  out  1  invalidate fetch stage.
- flush_dec  out  1  invalidate IF/DEC register.
- pend_cnt  out  $clog2(MAX_PEND+1)  outstanding tracked loads.
- scoreboard  out  NUM_REGS  pending-load bit per register.

Behaviour:
- Reset values (async, rst_n=0): scoreboard=0, pend_cnt=0, FSM=RUN, flush counter=0.
  - Resulting outputs: dec_issue=0, stall_fe=0, stall_dec=0, bubble_ex=0, flush_fe=0, flush_dec=0.
  - Reset mid-operation drops all pending state immediately.
- clr_mask: one-hot of wb_load_rd when wb_load_valid && wb_load_rd≠0, else 0.
- sb_eff = scoreboard & ~clr_mask (same-cycle writeback bypass; regfile is write-through).
- hazard = dec_valid && any of:
  - dec_use_rs1 && rs1≠0 && sb_eff[rs1]
  - dec_use_rs2 && rs2≠0 && sb_eff[rs2]
  - dec_reg_wen && rd≠0 && sb_eff[rd] (WAW)
  - dec_load && rd≠0 && pend_cnt==MAX_PEND && no clear this cycle
- FSM states: RUN, STALL, FLUSH.
  - RUN: ex_redirect → FLUSH; else hazard → STALL; else stay.
  - STALL: ex_redirect → FLUSH; else !hazard → RUN; else stay.
  - FLUSH: counter loaded with FLUSH_CYCLES-1 on entry and decremented each cycle. Return to RUN when counter==0 and no new ex_redirect. ex_redirect in FLUSH reloads the counter.
- Outputs (combinational from state and inputs):
  - flush_fe = flush_dec = ex_redirect || state==FLUSH.
  - stall_fe = stall_dec = bubble_ex = hazard && !flush_dec.
  - dec_issue = dec_valid && !hazard && !flush_dec.
- Redirect has priority over stall: the killed decode instruction never sets the scoreboard.
- Scoreboard set: dec_issue && dec_load && rd≠0 sets scoreboard[rd] and increments pend_cnt.
- Scoreboard clear: clr_mask bit set in scoreboard clears that bit and decrements pend_cnt. A writeback to a non-pending register is ignored, no count change.
- Set and clear of the same register in one cycle: bit ends 1, pend_cnt unchanged.
- Set and clear of different registers in one cycle: pend_cnt unchanged.
- pend_cnt never exceeds MAX_PEND and never underflows.
- Latency: a load issued in cycle N is visible to the decode hazard check in cycle N+1.

Optional Feature:
- Macro: DEC_HAZARD_PERF_EN.
- Defined: adds outputs perf_stall_cycles and perf_flush_cycles, each CNT_WIDTH wide.
  - perf_stall_cycles increments each cycle stall_dec=1.
  - perf_flush_cycles increments each cycle flush_dec=1.
  - Both saturate at all-ones and reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Load-use RAW: issue LW x5 (rd=5, dec_load=1); next cycle ADD rs1=5 → stall_dec=bubble_ex=1, scoreboard[5]=1, pend_cnt=1. wb_load_valid with rd=5 → in that same cycle stall=0, dec_issue=1, then scoreboard[5]=0, pend_cnt=0.
- x0 immunity: LW x0 issue → scoreboard=0, pend_cnt=0. Following ADD rs1=0 → no stall.
- Pend limit: 4 loads to x1..x4 outstanding with no writeback; 5th LW to x6 → stall. wb x2 same cycle → 5th issues, pend_cnt stays 4, scoreboard[2]=0, scoreboard[6]=1.
- Redirect during stall: hazard active plus ex_redirect → flush_fe=flush_dec=1 for 2 cycles, stall=0, dec_issue=0, scoreboard unchanged, FSM returns to RUN.
- Back-to-back redirect: ex_redirect in the 2nd flush cycle → flush held 2 more cycles (3 total after the first).
- Async reset with pend_cnt=3 and FSM=FLUSH: rst_n low mid-cycle → all outputs 0 immediately. After release, an ADD reading x1..x4 issues with no stall.
